// File: rtl/noisy_wave_gen.sv
`default_nettype none
// ============================================================================
// Module   : noisy_wave_gen
// Purpose  : Phase-accumulator waveform plus scaled LFSR noise, saturated and
//            emitted at a programmable sample rate for the scope FIR datapath.
// Revision : 1.0 - initial release
// ============================================================================
module noisy_wave_gen #(
  parameter int          DATA_WIDTH  = 12,
  parameter int          PHASE_WIDTH = 24,
  parameter int          DIV_WIDTH   = 16,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [1:0]             wave_sel,
  input  logic [PHASE_WIDTH-1:0] freq_word,
  input  logic [DIV_WIDTH-1:0]   sample_div,
  input  logic [3:0]             noise_shift,
  output logic [DATA_WIDTH-1:0]  noisy_signal,
  output logic [DATA_WIDTH-1:0]  clean_signal,
  output logic                   sample_valid,
  output logic                   phase_wrap
);

  localparam logic [DATA_WIDTH-1:0] c_min = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] c_max = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DIV_WIDTH-1:0]  c_one = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

  // divider and stage A state
  logic [DIV_WIDTH-1:0]   r_cnt;
  logic [PHASE_WIDTH-1:0] r_phase;
  logic [15:0]            r_lfsr;
  logic [1:0]             r_sel_sh;
  logic [3:0]             r_ns_sh;
  logic                   r_valid_a;
  logic                   r_wrap_a;

  // stage B state
  logic [DATA_WIDTH-1:0]  r_wave_b;
  logic [DATA_WIDTH-1:0]  r_noise_b;
  logic                   r_valid_b;
  logic                   r_wrap_b;

  logic                   w_tick;
  logic [DATA_WIDTH-1:0]  w_p;
  logic [DATA_WIDTH-2:0]  w_tri_u;
  logic [DATA_WIDTH-1:0]  w_wave;
  logic signed [DATA_WIDTH-1:0] w_noise;
  logic [DATA_WIDTH:0]    w_sum;
  logic [DATA_WIDTH-1:0]  w_sat;

  assign w_tick = enable && (r_cnt == sample_div);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_phase   <= '0;
      r_lfsr    <= LFSR_SEED;
      r_sel_sh  <= '0;
      r_ns_sh   <= '0;
      r_valid_a <= 1'b0;
      r_wrap_a  <= 1'b0;
    end else begin
      if (!enable || w_tick) r_cnt <= '0;
      else                   r_cnt <= r_cnt + c_one;
      r_valid_a <= w_tick;
      if (w_tick) begin
        {r_wrap_a, r_phase} <= {1'b0, r_phase} + {1'b0, freq_word};
        r_lfsr   <= r_lfsr[0] ? ((r_lfsr >> 1) ^ 16'hB400) : (r_lfsr >> 1);
        r_sel_sh <= wave_sel;
        r_ns_sh  <= noise_shift;
      end
    end
  end

  // Offset-binary to two's complement is an MSB flip, so saw/triangle just XOR c_min.
  always_comb begin
    w_p     = r_phase[PHASE_WIDTH-1 -: DATA_WIDTH];
    w_tri_u = w_p[DATA_WIDTH-1] ? ~w_p[DATA_WIDTH-2:0] : w_p[DATA_WIDTH-2:0];
    w_wave  = '0;
    case (r_sel_sh)
      2'd0:    w_wave = w_p[DATA_WIDTH-1] ? c_min : c_max;
      2'd1:    w_wave = {w_tri_u, 1'b0} ^ c_min;
      2'd2:    w_wave = w_p ^ c_min;
      default: w_wave = '0;
    endcase
    if (r_ns_sh == 4'd15) w_noise = '0;
    else                  w_noise = $signed(r_lfsr[DATA_WIDTH-1:0]) >>> r_ns_sh;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wave_b  <= '0;
      r_noise_b <= '0;
      r_valid_b <= 1'b0;
      r_wrap_b  <= 1'b0;
    end else begin
      r_valid_b <= r_valid_a;
      r_wrap_b  <= r_wrap_a;
      if (r_valid_a) begin
        r_wave_b  <= w_wave;
        r_noise_b <= w_noise;
      end
    end
  end

  // Overflow shows as the two top bits of the widened sum disagreeing.
  always_comb begin
    w_sum = {r_wave_b[DATA_WIDTH-1], r_wave_b} + {r_noise_b[DATA_WIDTH-1], r_noise_b};
    if (w_sum[DATA_WIDTH] != w_sum[DATA_WIDTH-1])
      w_sat = w_sum[DATA_WIDTH] ? c_min : c_max;
    else
      w_sat = w_sum[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      noisy_signal <= '0;
      clean_signal <= '0;
      sample_valid <= 1'b0;
      phase_wrap   <= 1'b0;
    end else begin
      sample_valid <= r_valid_b;
      phase_wrap   <= r_valid_b && r_wrap_b;
      if (r_valid_b) begin
        noisy_signal <= w_sat;
        clean_signal <= r_wave_b;
      end
    end
  end

endmodule
`default_nettype wire
